// File: rtl/delay_timer_scheduler.sv
// delay_timer_scheduler
//   Shares one countdown delay timer between NUM_REQ requesters. Requests are
//   arbitrated round-robin, the granted delay is loaded into a shared
//   down-counter that is paced by a prescaler (PRESCALE clk cycles per tick),
//   and a one-cycle completion pulse is returned to the owner.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   req       per-requester level request, held until done or abort
//   delay     requested tick counts, slice i = delay[i*CNT_W +: CNT_W]
//   grant     one-hot owner of the timer, zero when idle
//   done      one-cycle pulse on the owner's bit when its delay expires
//   busy      timer in use
//   count_out remaining ticks of the current delay
module delay_timer_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         count_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} stateT;

    stateT             state, stateNext;
    logic [IDX_W-1:0]  grantIdx, grantIdxNext;
    logic [IDX_W-1:0]  lastGrant, lastGrantNext;
    logic [PS_W-1:0]   prescaler, prescalerNext;
    logic [NUM_REQ-1:0] grantNext, doneNext;
    logic [CNT_W-1:0]  countNext, loadVal;
    logic              busyNext;
    logic [IDX_W-1:0]  pickIdx;
    logic              pickValid;

    // Round-robin pick: first set req bit scanning upward from lastGrant+1.
    always_comb begin : arbiter
        int unsigned cand;
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(lastGrant) + k) % NUM_REQ;
            if (!pickValid && req[IDX_W'(cand)]) begin
                pickValid = 1'b1;
                pickIdx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        stateNext     = state;
        grantIdxNext  = grantIdx;
        lastGrantNext = lastGrant;
        prescalerNext = prescaler;
        grantNext     = grant;
        doneNext      = '0;
        countNext     = count_out;
        loadVal       = '0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == IDX_W'(i)) begin
                loadVal = delay[i*CNT_W +: CNT_W];
            end
        end

        case (state)
            IDLE: begin
                if (pickValid) begin
                    grantIdxNext = pickIdx;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        grantNext[i] = (IDX_W'(i) == pickIdx);
                    end
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                countNext     = loadVal;
                prescalerNext = '0;
                if (loadVal == '0) begin
                    stateNext = DONE;
                    doneNext  = grant;
                end else begin
                    stateNext = COUNT;
                end
            end
            COUNT: begin
                // Abort takes precedence over a tick on the same edge, so
                // count_out freezes at the value it showed when req dropped.
                if (!req[grantIdx]) begin
                    stateNext = IDLE;
                    grantNext = '0;
                end else if (prescaler == PS_LAST) begin
                    prescalerNext = '0;
                    if (count_out != '0) begin
                        countNext = count_out - CNT_W'(1);
                    end
                    if (count_out == CNT_W'(1)) begin
                        stateNext = DONE;
                        doneNext  = grant;
                    end
                end else begin
                    prescalerNext = prescaler + PS_W'(1);
                end
            end
            DONE: begin
                lastGrantNext = grantIdx;
                grantNext     = '0;
                stateNext     = IDLE;
            end
            default: begin
                grantNext = '0;
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grantIdx  <= '0;
            lastGrant <= IDX_LAST;
            prescaler <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            count_out <= '0;
        end else begin
            state     <= stateNext;
            grantIdx  <= grantIdxNext;
            lastGrant <= lastGrantNext;
            prescaler <= prescalerNext;
            grant     <= grantNext;
            done      <= doneNext;
            busy      <= busyNext;
            count_out <= countNext;
        end
    end

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// tb_delay_timer_scheduler
//   Self-checking bench for delay_timer_scheduler. A timeline-based reference
//   model predicts every output each cycle: a service that starts its LOAD in
//   cycle g shows count D - (t-1)/PRESCALE at offset t and completes at offset
//   D*PRESCALE+1. Directed scenarios are followed by randomized traffic.
module tb_delay_timer_scheduler;

    localparam int N = 4;
    localparam int W = 16;
    localparam int P = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] delay = '0;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   count_out;

    always #5 clk = ~clk;

    delay_timer_scheduler #(.NUM_REQ(N), .CNT_W(W), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .req(req), .delay(delay),
        .grant(grant), .done(done), .busy(busy), .count_out(count_out)
    );

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = -1;

    // Reference model: one active service described by owner, start cycle and D.
    bit mActive = 1'b0;
    int mOwner  = 0;
    int mStart  = 0;
    int mD      = 0;
    int mLast   = N - 1;
    int mCount  = 0;

    int gOwnerQ[$];
    int gCycleQ[$];
    int dCycleQ[$];
    int doneCnt[N];
    int lastDone[N];
    logic [N-1:0] prevGrant = '0;

    function automatic int ownerOf(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int qAt(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        assert (got === exp) passCount++;
        else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic clearLogs();
        gOwnerQ.delete();
        gCycleQ.delete();
        dCycleQ.delete();
        for (int i = 0; i < N; i++) begin
            doneCnt[i]  = 0;
            lastDone[i] = -1;
        end
    endtask

    task automatic sampleCheck();
        logic [N-1:0] eg, ed;
        logic         eb;
        int           ec, t;
        @(posedge clk);
        #1;
        cyc++;
        t  = cyc - mStart;
        eg = '0;
        ed = '0;
        eb = 1'b0;
        ec = mCount;
        if (mActive) begin
            eg[mOwner] = 1'b1;
            eb = 1'b1;
            if (t >= 1) begin
                ec = mD - (t - 1) / P;
                if (t == mD * P + 1) ed = eg;
            end
        end
        check("grant", 32'(grant), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("busy", 32'(busy), 32'(eb));
        check("count_out", 32'(count_out), 32'(ec));
        mCount = ec;
        if (grant != '0 && prevGrant == '0) begin
            gOwnerQ.push_back(ownerOf(grant));
            gCycleQ.push_back(cyc);
        end
        prevGrant = grant;
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                doneCnt[i]++;
                lastDone[i] = cyc;
                dCycleQ.push_back(cyc);
            end
        end
    endtask

    // Inputs of the current cycle decide the model state of the next one.
    task automatic advance();
        int t;
        if (rst) begin
            mActive = 1'b0;
            mCount  = 0;
            mLast   = N - 1;
        end else if (mActive) begin
            t = cyc - mStart;
            if (t == 0) mD = int'(delay[mOwner*W +: W]);
            else if (t == mD * P + 1) begin
                mLast   = mOwner;
                mActive = 1'b0;
            end else if (!req[mOwner]) mActive = 1'b0;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (mLast + k) % N;
                if (req[cand]) begin
                    mOwner  = cand;
                    mActive = 1'b1;
                    mStart  = cyc + 1;
                    break;
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rs);
        sampleCheck();
        req   = r;
        delay = d;
        rst   = rs;
        advance();
    endtask

    // Requesters in mask hold req until the cycle after their done pulse.
    task automatic service(input logic [N-1:0] mask, input logic [N*W-1:0] d, input int maxCycles);
        logic [N-1:0] cur, dropNext;
        int n;
        cur      = mask;
        dropNext = '0;
        n        = 0;
        cycle(cur, d, 1'b0);
        while ((cur != '0 || mActive) && n < maxCycles) begin
            sampleCheck();
            cur      = cur & ~dropNext;
            dropNext = done & cur;
            req      = cur;
            delay    = d;
            rst      = 1'b0;
            advance();
            n++;
        end
        check("service_bound", 32'(n < maxCycles), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   rq, dropR;
        logic           rr;
        int             s;
        bit             drop0;

        clearLogs();
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_count", 32'(count_out), 32'(0));
        cycle('0, '0, 1'b0);
        cycle('0, '0, 1'b0);

        // Single request, delay 10
        clearLogs();
        d = '0;
        d[0*W +: W] = 16'd10;
        s = cyc + 1;
        service(4'b0001, d, 60);
        check("s1_owner", 32'(qAt(gOwnerQ, 0)), 32'(0));
        check("s1_grant_cycle", 32'(qAt(gCycleQ, 0) - s), 32'(1));
        check("s1_done_cycle", 32'(lastDone[0] - s), 32'(22));
        check("s1_done_count", 32'(doneCnt[0]), 32'(1));

        // Zero delay
        clearLogs();
        d = '0;
        s = cyc + 1;
        service(4'b0010, d, 20);
        check("s2_owner", 32'(qAt(gOwnerQ, 0)), 32'(1));
        check("s2_grant_cycle", 32'(qAt(gCycleQ, 0) - s), 32'(1));
        check("s2_done_cycle", 32'(lastDone[1] - s), 32'(2));

        // Contention after reset
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b0);
        clearLogs();
        d = '0;
        d[0*W +: W] = 16'd3;
        d[2*W +: W] = 16'd3;
        s = cyc + 1;
        service(4'b0101, d, 60);
        check("s3_first_owner", 32'(qAt(gOwnerQ, 0)), 32'(0));
        check("s3_done0_cycle", 32'(lastDone[0] - s), 32'(8));
        check("s3_second_owner", 32'(qAt(gOwnerQ, 1)), 32'(2));
        check("s3_grant2_cycle", 32'(qAt(gCycleQ, 1) - s), 32'(10));
        check("s3_done2_cycle", 32'(lastDone[2] - s), 32'(17));

        // Round-robin with all requests held, delay 1
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b0);
        clearLogs();
        for (int i = 0; i < N; i++) d[i*W +: W] = 16'd1;
        s = cyc + 1;
        for (int k = 0; k < 25; k++) cycle(4'b1111, d, 1'b0);
        for (int k = 0; k < 4; k++) cycle('0, d, 1'b0);
        for (int k = 0; k < 5; k++) check("s4_order", 32'(qAt(gOwnerQ, k)), 32'(k % N));
        check("s4_done_total", 32'(dCycleQ.size()), 32'(5));
        check("s4_first_done", 32'(qAt(dCycleQ, 0) - s), 32'(4));
        for (int k = 0; k < 4; k++)
            check("s4_done_spacing", 32'(qAt(dCycleQ, k + 1) - qAt(dCycleQ, k)), 32'(P + 3));

        // Abort of a long delay, pending requester served next
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b0);
        clearLogs();
        d = '0;
        d[3*W +: W] = 16'd100;
        d[0*W +: W] = 16'd2;
        s = cyc + 1;
        drop0 = 1'b0;
        for (int k = 0; k < 36; k++) begin
            rq = '0;
            if (k < 20) rq[3] = 1'b1;
            if (k >= 5 && !drop0) rq[0] = 1'b1;
            cycle(rq, d, 1'b0);
            if (done[0]) drop0 = 1'b1;
        end
        check("s5_first_owner", 32'(qAt(gOwnerQ, 0)), 32'(3));
        check("s5_abort_no_done", 32'(doneCnt[3]), 32'(0));
        check("s5_next_owner", 32'(qAt(gOwnerQ, 1)), 32'(0));
        check("s5_next_grant_cycle", 32'(qAt(gCycleQ, 1) - s), 32'(22));
        check("s5_done0_cycle", 32'(lastDone[0] - s), 32'(27));

        // Reset in the middle of a delay-50 service
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b0);
        clearLogs();
        d = '0;
        d[1*W +: W] = 16'd50;
        d[0*W +: W] = 16'd1;
        d[2*W +: W] = 16'd1;
        for (int k = 0; k < 15; k++) cycle(4'b0010, d, 1'b0);
        cycle('0, d, 1'b1);
        cycle('0, d, 1'b0);
        check("s6_grant", 32'(grant), 32'(0));
        check("s6_done", 32'(done), 32'(0));
        check("s6_busy", 32'(busy), 32'(0));
        check("s6_count", 32'(count_out), 32'(0));
        check("s6_no_done1", 32'(doneCnt[1]), 32'(0));
        clearLogs();
        service(4'b0101, d, 40);
        check("s6_priority0", 32'(qAt(gOwnerQ, 0)), 32'(0));
        check("s6_then2", 32'(qAt(gOwnerQ, 1)), 32'(2));

        // Randomized traffic
        rq    = '0;
        dropR = '0;
        dr_init: for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom_range(0, 6));
        for (int n = 0; n < 3000; n++) begin
            sampleCheck();
            for (int i = 0; i < N; i++) begin
                if (dropR[i]) begin
                    rq[i]    = 1'b0;
                    dropR[i] = 1'b0;
                end else if (done[i]) begin
                    dropR[i] = ($urandom_range(0, 9) != 0);
                end else if (rq[i] && grant[i] && $urandom_range(0, 59) == 0) begin
                    rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(0, 5) == 0) begin
                    rq[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0)
                    d[i*W +: W] = W'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 25 : 6));
            end
            rr    = ($urandom_range(0, 399) == 0);
            req   = rq;
            delay = d;
            rst   = rr;
            advance();
        end
        for (int k = 0; k < 5; k++) cycle('0, d, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
